coproc_custom0_arbiter: RTL

Shares one custom0 stream coprocessor between two requesting cores (ports m0, m1) using round-robin arbitration with session locking. A requester holding its lock keeps exclusive ownership, so the coprocessor's accumulated state is never interleaved between requesters. Coprocessor responses return in order and are steered back to the issuing requester through an internal owner-tag FIFO. The block sits between the tiles' custom0 request/response streams and the single coprocessor wrapper instance.

---
 rtl/coproc_custom0_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/coproc_custom0_arbiter.sv
// Two-requester round-robin arbiter with session locking in front of one custom0
// stream coprocessor; an owner-tag FIFO steers in-order responses back.
module coproc_custom0_arbiter #(
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned REQ_W     = 32,
  parameter int unsigned RESP_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_stream_req_bus_genfifo_req_i,
  input  logic [REQ_W-1:0]  m0_stream_req_bus_genfifo_rdata_bi,
  output logic              m0_stream_req_bus_genfifo_ack_o,
  input  logic              m0_lock_i,
  output logic              m0_stream_resp_bus_genfifo_req_o,
  output logic [RESP_W-1:0] m0_stream_resp_bus_genfifo_wdata_bo,
  input  logic              m0_stream_resp_bus_genfifo_ack_i,
  input  logic              m1_stream_req_bus_genfifo_req_i,
  input  logic [REQ_W-1:0]  m1_stream_req_bus_genfifo_rdata_bi,
  output logic              m1_stream_req_bus_genfifo_ack_o,
  input  logic              m1_lock_i,
  output logic              m1_stream_resp_bus_genfifo_req_o,
  output logic [RESP_W-1:0] m1_stream_resp_bus_genfifo_wdata_bo,
  input  logic              m1_stream_resp_bus_genfifo_ack_i,
  output logic              cp_stream_req_bus_genfifo_req_o,
  output logic [REQ_W-1:0]  cp_stream_req_bus_genfifo_wdata_bo,
  input  logic              cp_stream_req_bus_genfifo_ack_i,
  input  logic              cp_stream_resp_bus_genfifo_req_i,
  input  logic [RESP_W-1:0] cp_stream_resp_bus_genfifo_rdata_bi,
  output logic              cp_stream_resp_bus_genfifo_ack_o,
  output logic              busy_o
);

  localparam int unsigned PW = $clog2(TAG_DEPTH);
  localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                 state, state_next;
  logic                   rr_last, rr_next;
  logic                   sel, grant, lock_sel;
  logic                   push, pop, full, empty, head, resp_ok;
  logic [TAG_DEPTH-1:0]   tags;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  assign full  = (count == CW'(TAG_DEPTH));
  assign empty = (count == '0);
  assign head  = tags[rd_ptr];

  always_comb begin
    sel   = 1'b0;
    grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_stream_req_bus_genfifo_req_i && m1_stream_req_bus_genfifo_req_i) begin
          sel   = ~rr_last;
          grant = 1'b1;
        end else if (m0_stream_req_bus_genfifo_req_i) begin
          sel   = 1'b0;
          grant = 1'b1;
        end else if (m1_stream_req_bus_genfifo_req_i) begin
          sel   = 1'b1;
          grant = 1'b1;
        end
      end
      OWN0: begin
        sel   = 1'b0;
        grant = m0_stream_req_bus_genfifo_req_i;
      end
      OWN1: begin
        sel   = 1'b1;
        grant = m1_stream_req_bus_genfifo_req_i;
      end
      default: ;
    endcase
  end

  // Outputs are gated by rst_i so they clear asynchronously, not just at the next edge.
  assign cp_stream_req_bus_genfifo_req_o    = rst_i & grant & ~full;
  assign cp_stream_req_bus_genfifo_wdata_bo = sel ? m1_stream_req_bus_genfifo_rdata_bi
                                                  : m0_stream_req_bus_genfifo_rdata_bi;
  assign m0_stream_req_bus_genfifo_ack_o = rst_i & grant & ~sel & ~full & cp_stream_req_bus_genfifo_ack_i;
  assign m1_stream_req_bus_genfifo_ack_o = rst_i & grant &  sel & ~full & cp_stream_req_bus_genfifo_ack_i;

  assign push     = cp_stream_req_bus_genfifo_req_o & cp_stream_req_bus_genfifo_ack_i;
  assign lock_sel = sel ? m1_lock_i : m0_lock_i;

  always_comb begin
    state_next = state;
    rr_next    = rr_last;
    if (push) rr_next = sel;
    unique case (state)
      IDLE: if (push && lock_sel) state_next = sel ? OWN1 : OWN0;
      OWN0: if (!m0_lock_i) state_next = IDLE;
      OWN1: if (!m1_lock_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_ok = rst_i & ~empty;
  assign m0_stream_resp_bus_genfifo_req_o    = resp_ok & ~head & cp_stream_resp_bus_genfifo_req_i;
  assign m1_stream_resp_bus_genfifo_req_o    = resp_ok &  head & cp_stream_resp_bus_genfifo_req_i;
  assign m0_stream_resp_bus_genfifo_wdata_bo = (resp_ok & ~head) ? cp_stream_resp_bus_genfifo_rdata_bi : '0;
  assign m1_stream_resp_bus_genfifo_wdata_bo = (resp_ok &  head) ? cp_stream_resp_bus_genfifo_rdata_bi : '0;
  assign cp_stream_resp_bus_genfifo_ack_o    = resp_ok & (head ? m1_stream_resp_bus_genfifo_ack_i
                                                               : m0_stream_resp_bus_genfifo_ack_i);
  assign pop = cp_stream_resp_bus_genfifo_req_i & cp_stream_resp_bus_genfifo_ack_o;

  assign busy_o = (state != IDLE) | ~empty;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      tags    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_next;
      rr_last <= rr_next;
      if (push) begin
        tags[wr_ptr] <= sel;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
